uart_simctl: RTL and testbench

Memory-mapped console and simulation-control peripheral inside `minisoc_top`, sitting between the CPU data bus and the SoC's top-level `uart_tx_valid`/`uart_tx_data` and `sim_done`/`sim_exit_code` outputs. Software writes characters into a small TX FIFO, which drains at a programmable pace into one-cycle byte strobes. A write to the exit register ends the simulation only after every queued byte has been emitted, so the bench always prints complete output before `[sim] done`.

---
 rtl/simctl_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_simctl.sv | 180 ++++++++++++++++++
 tb/tb_uart_simctl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simctl_pkg.sv
// Shared constants for the console / simulation-control peripheral:
// register offsets, STATUS bit layout, divider width and sequencer states.
package simctl_pkg;

  localparam logic [3:0] SIMCTL_TXDATA = 4'h0;
  localparam logic [3:0] SIMCTL_STATUS = 4'h4;
  localparam logic [3:0] SIMCTL_EXIT   = 4'h8;
  localparam logic [3:0] SIMCTL_DIV    = 4'hC;

  localparam int ST_FULL         = 0;
  localparam int ST_EMPTY        = 1;
  localparam int ST_EXIT_PENDING = 2;
  localparam int ST_DONE         = 3;
  localparam int ST_COUNT_LSB    = 8;

  localparam int SIMCTL_DIV_W = 16;

  localparam logic [1:0] SEQ_RUN     = 2'd0;
  localparam logic [1:0] SEQ_PENDING = 2'd1;
  localparam logic [1:0] SEQ_DONE    = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are dropped, so callers may assert them unconditionally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, head-of-queue data and qualified push/pop strobes.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == {CW{1'b0}});
    count     = count_r;
    rdata     = mem_r[rd_ptr_r];
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_simctl.sv
// Console and simulation-control peripheral: register decode, paced TX drain
// and an exit sequencer that waits for the console to go quiet before
// raising sim_done.
module uart_simctl
  import simctl_pkg::*;
#(
  parameter int                      FIFO_DEPTH = 8,
  parameter logic [SIMCTL_DIV_W-1:0] DIV_RESET  = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  output logic        sim_done,
  output logic [31:0] sim_exit_code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] SEL_TXDATA = SIMCTL_TXDATA[3:2];
  localparam logic [1:0] SEL_STATUS = SIMCTL_STATUS[3:2];
  localparam logic [1:0] SEL_EXIT   = SIMCTL_EXIT[3:2];
  localparam logic [1:0] SEL_DIV    = SIMCTL_DIV[3:2];

  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [CW-1:0]           fifo_count_s;
  logic [7:0]              fifo_head_s;
  logic [1:0]              reg_sel_s;
  logic                    tx_wr_s;
  logic                    stall_s;
  logic                    accept_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    exit_wr_s;
  logic                    div_wr_s;
  logic [31:0]             status_s;
  logic [31:0]             rd_mux_s;
  logic                    unused_s;

  logic [SIMCTL_DIV_W-1:0] div_r;
  logic [SIMCTL_DIV_W-1:0] gap_r;
  logic [1:0]              seq_r;
  logic [31:0]             exit_code_r;
  logic [31:0]             bus_rdata_r;
  logic                    bus_rvalid_r;
  logic                    tx_valid_r;
  logic [7:0]              tx_data_r;
  logic                    sim_done_r;
  logic [31:0]             sim_exit_code_r;

  assign unused_s = ^bus_addr[1:0];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus_wdata[7:0]),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Bus decode: stall only real pushes into a full FIFO while still running.
  always_comb begin
    reg_sel_s = bus_addr[3:2];
    tx_wr_s   = bus_valid && bus_we && (reg_sel_s == SEL_TXDATA) && bus_wstrb[0];
    stall_s   = rst_n && tx_wr_s && fifo_full_s && (seq_r == SEQ_RUN);
    bus_ready = !stall_s;
    accept_s  = bus_valid && !stall_s;
    push_s    = accept_s && tx_wr_s && (seq_r == SEQ_RUN);
    pop_s     = !fifo_empty_s && (gap_r == {SIMCTL_DIV_W{1'b0}});
    exit_wr_s = accept_s && bus_we && (reg_sel_s == SEL_EXIT) && (bus_wstrb != 4'b0000);
    div_wr_s  = accept_s && bus_we && (reg_sel_s == SEL_DIV);
  end

  // Read data selection, STATUS word assembled from live state.
  always_comb begin
    status_s                        = 32'd0;
    status_s[ST_FULL]               = fifo_full_s;
    status_s[ST_EMPTY]              = fifo_empty_s;
    status_s[ST_EXIT_PENDING]       = (seq_r == SEQ_PENDING);
    status_s[ST_DONE]               = (seq_r == SEQ_DONE);
    status_s[ST_COUNT_LSB +: 8]     = 8'(fifo_count_s);
    case (reg_sel_s)
      SEL_TXDATA: rd_mux_s = 32'd0;
      SEL_STATUS: rd_mux_s = status_s;
      SEL_EXIT:   rd_mux_s = exit_code_r;
      SEL_DIV:    rd_mux_s = {16'd0, div_r};
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Registered read response, one-cycle rvalid pulse per accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_rdata_r  <= 32'd0;
      bus_rvalid_r <= 1'b0;
    end else if (accept_s && !bus_we) begin
      bus_rdata_r  <= rd_mux_s;
      bus_rvalid_r <= 1'b1;
    end else begin
      bus_rvalid_r <= 1'b0;
    end
  end

  // DIV register, byte-lane writable; only consulted when the gap reloads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r <= DIV_RESET;
    end else if (div_wr_s) begin
      if (bus_wstrb[0]) div_r[7:0]  <= bus_wdata[7:0];
      if (bus_wstrb[1]) div_r[15:8] <= bus_wdata[15:8];
    end
  end

  // Drain engine: emit the head byte when the gap has expired, then reload it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
      gap_r      <= {SIMCTL_DIV_W{1'b0}};
    end else if (pop_s) begin
      tx_valid_r <= 1'b1;
      tx_data_r  <= fifo_head_s;
      gap_r      <= div_r;
    end else begin
      tx_valid_r <= 1'b0;
      if (gap_r != {SIMCTL_DIV_W{1'b0}}) begin
        gap_r <= gap_r - SIMCTL_DIV_W'(1'b1);
      end
    end
  end

  // Exit sequencer: first EXIT code wins; done only once the console is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_r           <= SEQ_RUN;
      exit_code_r     <= 32'd0;
      sim_done_r      <= 1'b0;
      sim_exit_code_r <= 32'd0;
    end else begin
      case (seq_r)
        SEQ_RUN: begin
          if (exit_wr_s) begin
            exit_code_r <= bus_wdata;
            seq_r       <= SEQ_PENDING;
          end
        end
        SEQ_PENDING: begin
          if (fifo_empty_s && !tx_valid_r) begin
            seq_r           <= SEQ_DONE;
            sim_done_r      <= 1'b1;
            sim_exit_code_r <= exit_code_r;
          end
        end
        SEQ_DONE: seq_r <= SEQ_DONE;
        default:  seq_r <= SEQ_RUN;
      endcase
    end
  end

  assign bus_rdata     = bus_rdata_r;
  assign bus_rvalid    = bus_rvalid_r;
  assign uart_tx_valid = tx_valid_r;
  assign uart_tx_data  = tx_data_r;
  assign sim_done      = sim_done_r;
  assign sim_exit_code = sim_exit_code_r;

endmodule

// File: tb/tb_uart_simctl.sv
// Scoreboard bench for uart_simctl: stimulus pushes expected bytes and read
// data into queues, an independent negedge monitor pops and compares.
module tb_uart_simctl;
  import simctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        sim_done;
  logic [31:0] sim_exit_code;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int stall_cycles = 0;
  int done_cyc = -1;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  int          exp_rd_cyc[$];
  int          strobe_cyc[$];

  uart_simctl #(.FIFO_DEPTH(8), .DIV_RESET(16'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_valid     (bus_valid),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_ready     (bus_ready),
    .bus_rdata     (bus_rdata),
    .bus_rvalid    (bus_rvalid),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .sim_done      (sim_done),
    .sim_exit_code (sim_exit_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares strobes and read responses against the queues.
  always @(negedge clk) begin
    if (uart_tx_valid === 1'b1) begin
      strobe_cyc.push_back(cyc);
      if (exp_tx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got 0x%02h, expected no strobe (cycle %0d)", uart_tx_data, cyc);
      end else begin
        check32("tx_data", {24'd0, uart_tx_data}, {24'd0, exp_tx.pop_front()});
      end
    end
    if (bus_rvalid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got 0x%08h, expected no read (cycle %0d)", bus_rdata, cyc);
      end else begin
        check32("rdata", bus_rdata, exp_rd.pop_front());
        check32("rvalid_cycle", cyc, exp_rd_cyc.pop_front());
      end
    end
    if (sim_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] exp_r);
    int n;
    n = 0;
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    bus_wstrb = st;
    #1;
    while (bus_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    stall_cycles = n;
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got bus_ready=0 for %0d cycles, expected acceptance", n);
    end
    if (!we) begin
      exp_rd.push_back(exp_r);
      exp_rd_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    bus_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] st);
    bus_xfer(1'b1, addr, wd, st, 32'd0);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp_r);
    bus_xfer(1'b0, addr, 32'd0, 4'b0000, exp_r);
  endtask

  task automatic tx(input logic [7:0] b);
    exp_tx.push_back(b);
    wr(SIMCTL_TXDATA, {24'd0, b}, 4'b0001);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || uart_tx_valid === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check32("drain_complete", exp_tx.size(), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int a9;
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 4'h0;
    bus_wdata = 32'd0;
    bus_wstrb = 4'b0000;
    idle(2);

    // Reset state and bus_ready under reset.
    check32("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    check32("reset_sim_done", {31'd0, sim_done}, 32'd0);
    check32("reset_exit_code", sim_exit_code, 32'd0);
    check32("reset_rvalid_rdata", {31'd0, bus_rvalid} | bus_rdata, 32'd0);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = SIMCTL_TXDATA;
    bus_wstrb = 4'b0001;
    #1;
    check32("reset_bus_ready", {31'd0, bus_ready}, 32'd1);
    bus_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // DIV lane write: only lane 0 lands.
    wr(SIMCTL_DIV, 32'h12345678, 4'b0001);
    rd(SIMCTL_DIV, 32'h00000078);
    wr(SIMCTL_DIV, 32'd0, 4'b0011);

    // Back-to-back bytes with DIV = 0.
    strobe_cyc.delete();
    tx(8'h48);
    a0 = acc_cyc;
    tx(8'h69);
    tx(8'h0A);
    wait_drain(50);
    check32("t1_strobe_count", strobe_cyc.size(), 32'd3);
    if (strobe_cyc.size() >= 3) begin
      check32("t1_first_latency", strobe_cyc[0], a0 + 1);
      check32("t1_consec_1", strobe_cyc[1], a0 + 2);
      check32("t1_consec_2", strobe_cyc[2], a0 + 3);
    end

    // Fill the FIFO during a long gap, then overflow by one with DIV = 3.
    wr(SIMCTL_DIV, 32'd40, 4'b0011);
    tx(8'hA0);
    wait_drain(60);
    wr(SIMCTL_DIV, 32'd3, 4'b0011);
    strobe_cyc.delete();
    for (int i = 0; i < 8; i++) tx(8'hB0 + 8'(i));
    rd(SIMCTL_STATUS, 32'h00000801);
    tx(8'hB8);
    a9 = acc_cyc;
    check32("t2_ninth_stalled", {31'd0, (stall_cycles > 0)}, 32'd1);
    wait_drain(100);
    check32("t2_strobe_count", strobe_cyc.size(), 32'd9);
    if (strobe_cyc.size() >= 9) begin
      check32("t2_ninth_after_pop", a9, strobe_cyc[0] + 1);
      for (int i = 1; i < 9; i++) check32("t2_spacing", strobe_cyc[i] - strobe_cyc[i-1], 32'd4);
    end

    // Exit after 4 bytes with DIV = 5, plus discarded TXDATA while pending.
    idle(10);
    wr(SIMCTL_DIV, 32'd5, 4'b0011);
    strobe_cyc.delete();
    done_cyc = -1;
    for (int i = 0; i < 4; i++) tx(8'hC0 + 8'(i));
    wr(SIMCTL_EXIT, 32'h0000002A, 4'b1111);
    wr(SIMCTL_TXDATA, 32'h00000055, 4'b0001);
    check32("t4_ready_while_pending", stall_cycles, 32'd0);
    rd(SIMCTL_STATUS, 32'h00000304);
    wait_drain(100);
    idle(5);
    check32("t3_strobe_count", strobe_cyc.size(), 32'd4);
    if (strobe_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) check32("t3_spacing", strobe_cyc[i] - strobe_cyc[i-1], 32'd6);
      check32("t3_done_cycle", done_cyc, strobe_cyc[3] + 2);
    end
    check32("t3_exit_code", sim_exit_code, 32'h0000002A);
    wr(SIMCTL_EXIT, 32'h00000001, 4'b1111);
    idle(3);
    check32("t3_exit_code_kept", sim_exit_code, 32'h0000002A);
    check32("t3_done_sticky", {31'd0, sim_done}, 32'd1);
    rd(SIMCTL_EXIT, 32'h0000002A);
    rd(SIMCTL_STATUS, 32'h0000000A);
    idle(20);

    // Reset mid-operation with bytes queued.
    pulse_reset();
    check32("t5_done_cleared", {31'd0, sim_done}, 32'd0);
    check32("t5_code_cleared", sim_exit_code, 32'd0);
    wr(SIMCTL_DIV, 32'd30, 4'b0011);
    strobe_cyc.delete();
    tx(8'hD0);
    for (int i = 1; i < 6; i++) wr(SIMCTL_TXDATA, {24'd0, 8'hD0 + 8'(i)}, 4'b0001);
    pulse_reset();
    idle(50);
    check32("t5_strobe_count", strobe_cyc.size(), 32'd1);
    rd(SIMCTL_STATUS, 32'h00000002);
    rd(SIMCTL_DIV, 32'h00000000);
    check32("t5_sim_done", {31'd0, sim_done}, 32'd0);

    idle(3);
    check32("tx_queue_empty", exp_tx.size(), 32'd0);
    check32("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
